// File: rtl/par_chk_rx.sv
// par_chk_rx: UART RX deserializer with parity check and saturating error count; `define PAR_CHK_STICKY_EN adds PAR_ERR_STKY.
module par_chk_rx #(
    parameter int WIDTH_DATA = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FRAME_START,
    input  logic                  BIT_STRB,
    input  logic                  SAMPLED_BIT,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ERR_CLR,
    output logic [WIDTH_DATA-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
`ifdef PAR_CHK_STICKY_EN
    output logic                  PAR_ERR_STKY,
`endif
    output logic [CNT_WIDTH-1:0]  ERR_CNT
);
    localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2, CHK = 2'd3;
    localparam int CW = $clog2(WIDTH_DATA + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH_DATA - 1);
    logic [1:0] state;
    logic [WIDTH_DATA-1:0] shreg;
    logic [CW-1:0] bit_cnt;
    logic par_en_q, par_typ_q, par_bit_q;
    logic exp_par, bad, in_chk, err_set, ok_set;
    // A FRAME_START landing in CHK aborts the frame, so neither pulse may fire.
    always_comb begin
        in_chk  = (state == CHK) && !FRAME_START;
        exp_par = par_typ_q ? ^shreg : ~^shreg;
        bad     = par_en_q && (exp_par != par_bit_q);
        err_set = in_chk && bad;
        ok_set  = in_chk && !bad;
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            ERR_CNT    <= '0;
        end else begin
            DATA_VALID <= ok_set;
            PAR_ERR    <= err_set;
            if (ok_set)
                P_DATA <= shreg;
            ERR_CNT <= ERR_CLR ? '0 : (err_set && !(&ERR_CNT)) ? ERR_CNT + CNT_WIDTH'(1) : ERR_CNT;
            if (FRAME_START) begin
                state     <= DATA;
                shreg     <= '0;
                bit_cnt   <= '0;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                par_bit_q <= 1'b0;
            end else begin
                case (state)
                    DATA: if (BIT_STRB) begin
                        shreg   <= {SAMPLED_BIT, shreg[WIDTH_DATA-1:1]};
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == LAST)
                            state <= par_en_q ? PAR : CHK;
                    end
                    PAR: if (BIT_STRB) begin
                        par_bit_q <= SAMPLED_BIT;
                        state     <= CHK;
                    end
                    CHK:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
`ifdef PAR_CHK_STICKY_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            PAR_ERR_STKY <= 1'b0;
        else
            PAR_ERR_STKY <= ERR_CLR ? 1'b0 : (err_set ? 1'b1 : PAR_ERR_STKY);
    end
`endif
endmodule

// File: tb/tb_par_chk_rx.sv
// tb_par_chk_rx: randomized frames against a word-level parity model of par_chk_rx.
module tb_par_chk_rx;
    logic CLK = 1'b0;
    logic RST, FRAME_START, BIT_STRB, SAMPLED_BIT, PAR_EN, PAR_TYP, ERR_CLR;
    logic [7:0] P_DATA;
    logic DATA_VALID, PAR_ERR;
    logic [1:0] ERR_CNT;
`ifdef PAR_CHK_STICKY_EN
    logic PAR_ERR_STKY;
`endif
    int checks = 0, failures = 0;
    logic [7:0] m_data;
    logic [1:0] m_cnt;
    logic m_stky;

    par_chk_rx #(.WIDTH_DATA(8), .CNT_WIDTH(2)) dut (
        .CLK(CLK), .RST(RST), .FRAME_START(FRAME_START), .BIT_STRB(BIT_STRB),
        .SAMPLED_BIT(SAMPLED_BIT), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ERR_CLR(ERR_CLR),
        .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR),
`ifdef PAR_CHK_STICKY_EN
        .PAR_ERR_STKY(PAR_ERR_STKY),
`endif
        .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pdata"}, 32'(P_DATA), 32'(m_data));
        check({tag, "_errcnt"}, 32'(ERR_CNT), 32'(m_cnt));
`ifdef PAR_CHK_STICKY_EN
        check({tag, "_stky"}, 32'(PAR_ERR_STKY), 32'(m_stky));
`endif
    endtask

    task automatic strobe(input logic b);
        repeat ($urandom_range(0, 2)) begin
            if ($urandom_range(0, 1) == 1) begin
                PAR_EN  = 1'($urandom);
                PAR_TYP = 1'($urandom);
            end
            tick();
            check("quiet", 32'({DATA_VALID, PAR_ERR}), 32'd0);
        end
        BIT_STRB = 1'b1;
        SAMPLED_BIT = b;
        tick();
        BIT_STRB = 1'b0;
        SAMPLED_BIT = 1'($urandom);
    endtask

    task automatic start_partial(input int n);
        FRAME_START = 1'b1;
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
        tick();
        FRAME_START = 1'b0;
        for (int i = 0; i < n; i++) strobe(1'($urandom));
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic flip, input logic clr, input logic coincident);
        logic p, bad;
        p = 1'(($countones(d) % 2) ^ (pt ? 0 : 1)) ^ flip;
        bad = pe && flip;
        FRAME_START = 1'b1;
        PAR_EN = pe;
        PAR_TYP = pt;
        if (coincident) begin
            BIT_STRB = 1'b1;
            SAMPLED_BIT = 1'b1;
        end
        tick();
        FRAME_START = 1'b0;
        BIT_STRB = 1'b0;
        for (int i = 0; i < 8; i++) strobe(d[i]);
        if (pe) strobe(p);
        if (!bad) m_data = d;
        if (clr) begin
            m_cnt = 2'd0;
            m_stky = 1'b0;
        end else if (bad) begin
            if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
            m_stky = 1'b1;
        end
        ERR_CLR = clr;
        tick();
        ERR_CLR = 1'b0;
        check("dv", 32'(DATA_VALID), 32'(!bad));
        check("perr", 32'(PAR_ERR), 32'(bad));
        check_state("frame");
        tick();
        check("pulse_fall", 32'({DATA_VALID, PAR_ERR}), 32'd0);
    endtask

    initial begin
        RST = 1'b0; FRAME_START = 1'b0; BIT_STRB = 1'b0; SAMPLED_BIT = 1'b0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; ERR_CLR = 1'b0;
        m_data = 8'h00; m_cnt = 2'd0; m_stky = 1'b0;
        tick(); tick();
        check("rst_pulses", 32'({DATA_VALID, PAR_ERR}), 32'd0);
        check_state("rst");
        RST = 1'b1;
        tick();
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        BIT_STRB = 1'b1;
        tick();
        BIT_STRB = 1'b0;
        tick();
        check("stray_strb", 32'({DATA_VALID, PAR_ERR}), 32'd0);
        check_state("stray");
        start_partial(4);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        m_cnt = 2'd0;
        m_stky = 1'b0;
        check_state("clr");
        for (int i = 0; i < 4; i++) send_frame(8'(i * 37), 1'b1, 1'(i), 1'b1, 1'b0, 1'b0);
        send_frame(8'h77, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        start_partial(5);
        #2 RST = 1'b0;
        #1;
        m_data = 8'h00; m_cnt = 2'd0; m_stky = 1'b0;
        check("async_rst_pulses", 32'({DATA_VALID, PAR_ERR}), 32'd0);
        check_state("async_rst");
        tick();
        RST = 1'b1;
        tick();
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) start_partial($urandom_range(0, 7));
            send_frame(8'($urandom), 1'($urandom), 1'($urandom),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
